// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives the J/K inputs of an external JK flop bank so its Q
// reaches a requested value (load) or inverts selected bits (toggle). Each
// attempt is one drive cycle, an optional settle delay and a check of the bank's
// Q. A failed check retries with the minimal load excitation until the retry
// budget is spent.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_IDLE   | waiting for a request; req_ready high
// ST_DRIVE  | J/K excitation presented to the bank for exactly one cycle
// ST_SETTLE | J/K idle (00) while the bank settles; SETTLE cycles long
// ST_CHECK  | compare bank Q with the expected value; finish or retry
module jk_bank_driver #(
   parameter int WIDTH     = 4,
   parameter int SETTLE    = 1,
   parameter int MAX_RETRY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_op,
   input  logic [WIDTH-1:0] req_data,
   output logic [WIDTH-1:0] jk_j,
   output logic [WIDTH-1:0] jk_k,
   input  logic [WIDTH-1:0] jk_q,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] fail_bits
);

   localparam int RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int SW        = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam int SETTLE_M1 = (SETTLE > 0) ? SETTLE - 1 : 0;

   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_M1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_CHECK  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] expected;
   logic [RW-1:0]    retry_cnt;
   logic [SW-1:0]    settle_cnt;
   logic             accept;
   logic             q_match;

   assign req_ready = (state == ST_IDLE);
   assign busy      = ~req_ready;
   assign accept    = req_valid && req_ready;
   assign q_match   = (jk_q == expected);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; the settle phase is bypassed entirely when SETTLE is 0.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            state_nxt = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_cnt == '0) begin
               state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (q_match) begin
               state_nxt = ST_IDLE;
            end else if (retry_cnt < RETRY_MAX) begin
               state_nxt = ST_DRIVE;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Excitation, expected value, counters and result pulses. J/K are computed on
   // the edge that enters DRIVE so they are registered during the drive cycle.
   // Retries always use the load form so a toggle is never applied twice.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         jk_j       <= '0;
         jk_k       <= '0;
         expected   <= '0;
         retry_cnt  <= '0;
         settle_cnt <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         fail_bits  <= '0;
      end else begin
         jk_j <= '0;
         jk_k <= '0;
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  retry_cnt <= '0;
                  fail_bits <= '0;
                  if (req_op) begin
                     expected <= jk_q ^ req_data;
                     jk_j     <= req_data;
                     jk_k     <= req_data;
                  end else begin
                     expected <= req_data;
                     jk_j     <= req_data & ~jk_q;
                     jk_k     <= ~req_data & jk_q;
                  end
               end
            end
            ST_DRIVE: begin
               settle_cnt <= SETTLE_LOAD;
            end
            ST_SETTLE: begin
               if (settle_cnt != '0) begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            ST_CHECK: begin
               if (q_match) begin
                  done      <= 1'b1;
                  fail_bits <= '0;
               end else if (retry_cnt < RETRY_MAX) begin
                  retry_cnt <= retry_cnt + 1'b1;
                  jk_j      <= expected & ~jk_q;
                  jk_k      <= ~expected & jk_q;
               end else begin
                  err       <= 1'b1;
                  fail_bits <= expected ^ jk_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: two instances (SETTLE=1 and SETTLE=0), each with a
// behavioural JK bank that can have stuck bits and can ignore its first N
// non-idle drives. Expected drive/result sequences come from an attempt-level
// model of the request.
module tb_jk_bank_driver;

   localparam int MAX_RETRY = 2;

   logic       clk;
   logic       reset;
   logic       req_valid [2];
   logic       req_ready [2];
   logic       req_op    [2];
   logic [3:0] req_data  [2];
   logic [3:0] jk_j      [2];
   logic [3:0] jk_k      [2];
   logic [3:0] bank_q    [2];
   logic       busy      [2];
   logic       done      [2];
   logic       err       [2];
   logic [3:0] fail_bits [2];

   logic       bank_load     [2];
   logic [3:0] bank_load_val [2];
   logic [3:0] stuck_mask    [2];
   logic [3:0] stuck_val     [2];
   int         ign_cfg       [2];
   int         ign_left      [2];

   logic [3:0] drv_j [3];
   logic [3:0] drv_k [3];

   int tests_run = 0;
   int failures  = 0;

   jk_bank_driver #(.WIDTH(4), .SETTLE(1), .MAX_RETRY(MAX_RETRY)) dut_s1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_op(req_op[0]), .req_data(req_data[0]),
      .jk_j(jk_j[0]), .jk_k(jk_k[0]), .jk_q(bank_q[0]),
      .busy(busy[0]), .done(done[0]), .err(err[0]), .fail_bits(fail_bits[0])
   );

   jk_bank_driver #(.WIDTH(4), .SETTLE(0), .MAX_RETRY(MAX_RETRY)) dut_s0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_op(req_op[1]), .req_data(req_data[1]),
      .jk_j(jk_j[1]), .jk_k(jk_k[1]), .jk_q(bank_q[1]),
      .busy(busy[1]), .done(done[1]), .err(err[1]), .fail_bits(fail_bits[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External JK bank: J/K 00 hold, 10 set, 01 reset, 11 toggle, then stuck bits.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (bank_load[i]) begin
            bank_q[i]   <= (bank_load_val[i] & ~stuck_mask[i]) | (stuck_val[i] & stuck_mask[i]);
            ign_left[i] <= ign_cfg[i];
         end else if (((jk_j[i] | jk_k[i]) != 4'b0) && (ign_left[i] > 0)) begin
            ign_left[i] <= ign_left[i] - 1;
         end else begin
            bank_q[i] <= (((jk_j[i] & ~bank_q[i]) | (~jk_k[i] & bank_q[i])) & ~stuck_mask[i])
                         | (stuck_val[i] & stuck_mask[i]);
         end
      end
   end

   task automatic load_bank(input int u, input logic [3:0] q0, input logic [3:0] smask,
                            input logic [3:0] sval, input int ign);
      req_valid[u]     = 1'b0;
      stuck_mask[u]    = smask;
      stuck_val[u]     = sval;
      ign_cfg[u]       = ign;
      bank_load_val[u] = q0;
      bank_load[u]     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bank_load[u] = 1'b0;
   endtask

   // Issues one request at a negedge with the unit idle and checks every cycle
   // through the done/err cycle. Returns at the negedge of that cycle.
   task automatic run_req(input int u, input bit op, input logic [3:0] data, input bit do_load,
                          input logic [3:0] q0, input logic [3:0] smask, input logic [3:0] sval,
                          input int ign, input bit hold, input string name);
      logic [3:0]  q, nq, e, fb, ej, ek;
      logic [3:0]  mj [3];
      logic [3:0]  mk [3];
      logic [10:0] exp_v, obs_v;
      int          att, p, t, ign_m, a_idx;
      bit          ok;
      if (do_load) load_bank(u, q0, smask, sval, ign);
      for (int i = 0; i < 3; i++) begin
         drv_j[i] = 4'b0;
         drv_k[i] = 4'b0;
         mj[i]    = 4'b0;
         mk[i]    = 4'b0;
      end
      q     = bank_q[u];
      ign_m = ign_left[u];
      e     = op ? (q ^ data) : data;
      ok    = 1'b0;
      att   = MAX_RETRY + 1;
      for (int a = 0; a <= MAX_RETRY; a++) begin
         if (a == 0 && op) begin
            mj[a] = data;
            mk[a] = data;
         end else begin
            mj[a] = e & ~q;
            mk[a] = ~e & q;
         end
         nq = q;
         if (ign_m > 0 && (mj[a] | mk[a]) != 4'b0) ign_m--;
         else nq = (mj[a] & ~q) | (~mk[a] & q);
         q = (nq & ~stuck_mask[u]) | (stuck_val[u] & stuck_mask[u]);
         if (q == e) begin
            ok  = 1'b1;
            att = a + 1;
            break;
         end
      end
      fb = ok ? 4'b0 : (e ^ q);
      p  = (u == 0) ? 3 : 2;
      t  = att * p + 1;

      tests_run++;
      if (req_ready[u] !== 1'b1) begin
         failures++;
         $display("FAIL %s ready_before_accept: got %b required 1", name, req_ready[u]);
      end
      req_valid[u] = 1'b1;
      req_op[u]    = op;
      req_data[u]  = data;
      @(posedge clk);
      for (int c = 1; c <= t; c++) begin
         @(negedge clk);
         if (hold) begin
            req_op[u]   = 1'($urandom);
            req_data[u] = 4'($urandom);
         end else begin
            req_valid[u] = 1'b0;
         end
         ej    = 4'b0;
         ek    = 4'b0;
         a_idx = (c - 1) / p;
         if (((c - 1) % p) == 0 && a_idx < att) begin
            ej = mj[a_idx];
            ek = mk[a_idx];
         end
         if (((c - 1) % p) == 0 && a_idx < 3) begin
            drv_j[a_idx] = jk_j[u];
            drv_k[a_idx] = jk_k[u];
         end
         exp_v = {ej, ek, (c < t), (c == t) && ok, (c == t) && !ok};
         obs_v = {jk_j[u], jk_k[u], busy[u], done[u], err[u]};
         tests_run++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL %s cycle %0d {j,k,busy,done,err}: got %b required %b", name, c, obs_v, exp_v);
         end
      end
      tests_run++;
      if ({req_ready[u], fail_bits[u]} !== {1'b1, fb}) begin
         failures++;
         $display("FAIL %s final {ready,fail_bits}: got %b required %b", name,
                  {req_ready[u], fail_bits[u]}, {1'b1, fb});
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_op[i] = 1'b0; req_data[i] = 4'b0;
         stuck_mask[i] = 4'b0; stuck_val[i] = 4'b0; ign_cfg[i] = 0;
         bank_load_val[i] = 4'b0; bank_load[i] = 1'b1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if ({jk_j[i], jk_k[i], req_ready[i], busy[i], done[i], err[i], fail_bits[i]} !== 16'b0000_0000_1000_0000) begin
            failures++;
            $display("FAIL reset_state unit%0d: got %b required 0000000010000000", i,
                     {jk_j[i], jk_k[i], req_ready[i], busy[i], done[i], err[i], fail_bits[i]});
         end
         bank_load[i] = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_load;
      run_req(0, 1'b0, 4'b1010, 1'b1, 4'b0110, 4'b0, 4'b0, 0, 1'b0, "load");
      tests_run++;
      if ({drv_j[0], drv_k[0]} !== 8'b1000_0100) begin
         failures++;
         $display("FAIL load_drive {j,k}: got %b required 10000100", {drv_j[0], drv_k[0]});
      end
      run_req(0, 1'b0, 4'b0110, 1'b1, 4'b0110, 4'b0, 4'b0, 0, 1'b0, "load_same");
      tests_run++;
      if ({drv_j[0], drv_k[0]} !== 8'b0) begin
         failures++;
         $display("FAIL load_same_drive {j,k}: got %b required 00000000", {drv_j[0], drv_k[0]});
      end
   endtask

   task automatic test_toggle;
      run_req(0, 1'b1, 4'b0011, 1'b1, 4'b0101, 4'b0, 4'b0, 0, 1'b0, "toggle");
      tests_run++;
      if ({drv_j[0], drv_k[0], bank_q[0]} !== 12'b0011_0011_0110) begin
         failures++;
         $display("FAIL toggle {j,k,q}: got %b required 001100110110", {drv_j[0], drv_k[0], bank_q[0]});
      end
   endtask

   task automatic test_stuck_err;
      run_req(0, 1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0001, 4'b0000, 0, 1'b0, "stuck");
      tests_run++;
      if ({drv_j[0], drv_k[0], drv_j[1], drv_k[1], drv_j[2], drv_k[2], fail_bits[0]} !==
          28'b0001_0000_0001_0000_0001_0000_0001) begin
         failures++;
         $display("FAIL stuck_drives_fail_bits: got %b required 0001000000010000000100000001",
                  {drv_j[0], drv_k[0], drv_j[1], drv_k[1], drv_j[2], drv_k[2], fail_bits[0]});
      end
      repeat (2) @(negedge clk);
      tests_run++;
      if (fail_bits[0] !== 4'b0001) begin
         failures++;
         $display("FAIL fail_bits_held: got %b required 0001", fail_bits[0]);
      end
   endtask

   task automatic test_reset_mid;
      load_bank(0, 4'b0000, 4'b0, 4'b0, 0);
      req_valid[0] = 1'b1; req_op[0] = 1'b0; req_data[0] = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      tests_run++;
      if (jk_j[0] !== 4'b1111) begin
         failures++;
         $display("FAIL reset_mid_drive j: got %b required 1111", jk_j[0]);
      end
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if ({jk_j[i], jk_k[i], req_ready[i], busy[i], done[i], err[i], fail_bits[i]} !== 16'b0000_0000_1000_0000) begin
            failures++;
            $display("FAIL reset_mid unit%0d: got %b required 0000000010000000", i,
                     {jk_j[i], jk_k[i], req_ready[i], busy[i], done[i], err[i], fail_bits[i]});
         end
      end
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests_run++;
         if ({busy[0], done[0], err[0], jk_j[0], jk_k[0], bank_q[0]} !== 15'b0) begin
            failures++;
            $display("FAIL reset_mid_after cycle %0d {busy,done,err,j,k,q}: got %b required 0", c,
                     {busy[0], done[0], err[0], jk_j[0], jk_k[0], bank_q[0]});
         end
      end
   endtask

   task automatic test_ignore_retry;
      run_req(0, 1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0, 4'b0, 1, 1'b0, "ignore");
      tests_run++;
      if ({drv_j[0], drv_k[0], drv_j[1], drv_k[1]} !== 16'b1111_1111_1111_0000) begin
         failures++;
         $display("FAIL ignore_retry_drives: got %b required 1111111111110000",
                  {drv_j[0], drv_k[0], drv_j[1], drv_k[1]});
      end
   endtask

   task automatic test_back_to_back;
      for (int u = 0; u < 2; u++) begin
         run_req(u, 1'b0, 4'b1100, 1'b1, 4'b0011, 4'b0, 4'b0, 0, 1'b1, "b2b_a");
         run_req(u, 1'b1, 4'b0101, 1'b0, 4'b0, 4'b0, 4'b0, 0, 1'b1, "b2b_b");
         run_req(u, 1'b0, 4'b1010, 1'b0, 4'b0, 4'b0, 4'b0, 0, 1'b0, "b2b_c");
      end
   endtask

   task automatic test_random;
      for (int u = 0; u < 2; u++) begin
         for (int n = 0; n < 25; n++) begin
            bit         op, ld, hold;
            logic [3:0] data, q0, sm, sv;
            int         ign;
            op   = 1'($urandom);
            data = 4'($urandom);
            ld   = ($urandom_range(0, 2) != 0);
            q0   = 4'($urandom);
            sm   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            sv   = 4'($urandom);
            ign  = $urandom_range(0, 2);
            hold = (n != 24) && ($urandom_range(0, 1) == 1);
            run_req(u, op, data, ld, q0, sm, sv, ign, hold, "random");
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_toggle();
      test_stuck_err();
      test_reset_mid();
      test_ignore_retry();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
